// File: rtl/fifo_rd_packer.sv
// Purpose: pops DWIDTH-wide FIFO entries and packs PACK of them (lane 0 first) into one word.
// Latency: out_valid rises the cycle after the pop that fills the last lane; one pop per cycle streaming.
// Backpressure: holds the word while out_ready=0 (no pops); a pop may overlap the handoff cycle.
// Optional: define FIFO_RD_PACKER_FLUSH_EN to add flush / out_lanes for emitting partial words.
module fifo_rd_packer #(
    parameter  int DWIDTH = 4,
    parameter  int PACK   = 4,
    localparam int CW     = $clog2(PACK + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    input  logic [DWIDTH-1:0]        fifo_dout,
    output logic                     fifo_ren,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DWIDTH*PACK-1:0]   out_data
`ifdef FIFO_RD_PACKER_FLUSH_EN
    ,
    input  logic                     flush,
    output logic [CW-1:0]            out_lanes
`endif
);

    localparam int W = DWIDTH * PACK;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [W-1:0]    data_q;
    logic            out_valid_q;
    logic            pop;
    logic            flush_take;
    logic            last_lane;

    assign cnt_d     = cnt_q + CW'(1);
    assign last_lane = (cnt_q == CW'(PACK - 1));

`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic [CW-1:0]   lanes_q;
    // A flush only means something when at least one lane holds data.
    assign flush_take = flush & (state_q == ST_FILL) & (cnt_q != '0);
    assign out_lanes  = lanes_q;
`else
    assign flush_take = 1'b0;
`endif

    // Pop whenever data is there and the word register can take it; the
    // out_ready -> fifo_ren path lets a pop overlap the handoff cycle.
    assign fifo_ren  = ~fifo_empty & ((state_q == ST_FILL) | out_ready) & ~flush_take;
    assign pop       = fifo_ren & ~fifo_empty;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

    // Fill/hold state machine with registered out_valid and word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            lanes_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (flush_take) begin
                        // Emit the partial word; unfilled lanes are already zero.
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
                        lanes_q     <= cnt_q;
`endif
                    end else if (pop) begin
                        for (int i = 0; i < PACK; i++) begin
                            if (cnt_q == CW'(i)) begin
                                data_q[i*DWIDTH +: DWIDTH] <= fifo_dout;
                            end
                        end
                        cnt_q <= cnt_d;
                        if (last_lane) begin
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
                            lanes_q     <= CW'(PACK);
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        // Handoff clears the word; an overlapping pop seeds lane 0.
                        state_q     <= ST_FILL;
                        out_valid_q <= 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
                        lanes_q     <= '0;
`endif
                        if (pop) begin
                            data_q <= W'(fifo_dout);
                            cnt_q  <= CW'(1);
                        end else begin
                            data_q <= '0;
                            cnt_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Purpose: directed bench for fifo_rd_packer with a queue-based reference model.
// Latency: inputs change 1 unit after the rising edge; outputs compared on the falling edge.
// Backpressure: out_ready driven per test; the bench FIFO pops on fifo_ren & ~fifo_empty.
module tb_fifo_rd_packer;

    localparam int DWIDTH = 4;
    localparam int PACK   = 4;
    localparam int CW     = $clog2(PACK + 1);
    localparam int W      = DWIDTH * PACK;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DWIDTH-1:0] fifo_dout = '0;
    logic              fifo_ren;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_data;
    logic              flush = 1'b0;
    logic [CW-1:0]     out_lanes_w;

    fifo_rd_packer #(.DWIDTH(DWIDTH), .PACK(PACK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FIFO_RD_PACKER_FLUSH_EN
        ,
        .flush      (flush),
        .out_lanes  (out_lanes_w)
`endif
    );

`ifndef FIFO_RD_PACKER_FLUSH_EN
    assign out_lanes_w = '0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Bench-side FIFO and stimulus knobs
    logic [DWIDTH-1:0] q[$];
    bit ready_v  = 1'b0;
    bit flush_v  = 1'b0;
    bit sparse   = 1'b0;
    bit gap      = 1'b0;
    bit edge_pop = 1'b0;

    // Reference model: lanes collected so far and whether a word is on offer
    logic [DWIDTH-1:0] m_lanes[$];
    bit m_hold = 1'b0;

    // Statistics gathered by the compare process
    int cyc = 0;
    int n_pops = 0;
    int n_valid = 0;
    int first_pop = -1;
    int last_pop = -1;
    logic [W-1:0] got[$];

    function automatic logic [W-1:0] pack_model();
        logic [W-1:0] r = '0;
        foreach (m_lanes[i]) r |= W'(m_lanes[i]) << (i * DWIDTH);
        return r;
    endfunction

    // Compare process: checks DUT against the model every falling edge, then advances the model
    always @(negedge clk) begin
        bit m_flush;
        bit exp_ren;
        cyc++;
        if (!rst_n) begin
            m_lanes.delete();
            m_hold   = 1'b0;
            edge_pop = 1'b0;
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_data", 64'(out_data), 64'd0);
            if (FLUSH_EN) chk("rst_lanes", 64'(out_lanes_w), 64'd0);
        end else begin
            m_flush = FLUSH_EN && flush && !m_hold && (m_lanes.size() > 0);
            exp_ren = !fifo_empty && (!m_hold || out_ready) && !m_flush;
            chk("valid", 64'(out_valid), 64'(m_hold));
            if (m_hold) begin
                chk("data", 64'(out_data), 64'(pack_model()));
                if (FLUSH_EN) chk("lanes", 64'(out_lanes_w), 64'(m_lanes.size()));
            end
            chk("ren", 64'(fifo_ren), 64'(exp_ren));

            edge_pop = fifo_ren && !fifo_empty;
            if (edge_pop) begin
                n_pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (out_valid) n_valid++;
            if (out_valid && out_ready) got.push_back(out_data);

            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 1'b0;
                    m_lanes.delete();
                    if (exp_ren) m_lanes.push_back(fifo_dout);
                end
            end else if (m_flush) begin
                m_hold = 1'b1;
            end else if (exp_ren) begin
                m_lanes.push_back(fifo_dout);
                if (m_lanes.size() == PACK) m_hold = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (edge_pop && q.size() > 0) void'(q.pop_front());
        gap        = sparse ? ~gap : 1'b0;
        fifo_empty = (q.size() == 0) || gap;
        fifo_dout  = fifo_empty ? DWIDTH'($urandom_range(0, 15)) : q[0];
        out_ready  = ready_v;
        flush      = flush_v;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_stats();
        got.delete();
        n_pops    = 0;
        n_valid   = 0;
        first_pop = -1;
        last_pop  = -1;
    endtask

    task automatic load(input int first, input int count);
        for (int i = 0; i < count; i++) q.push_back(DWIDTH'(first + i));
    endtask

    initial begin
        #1;
        chk("reset_valid_lit", 64'(out_valid), 64'd0);
        chk("reset_data_lit", 64'(out_data), 64'd0);
        chk("reset_ren_lit", 64'(fifo_ren), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(2);

        // 1: single word, ready high
        clear_stats();
        ready_v = 1'b1;
        load(1, 4);
        run(8);
        chk("t1_pops", 64'(n_pops), 64'd4);
        chk("t1_span", 64'(last_pop - first_pop + 1), 64'd4);
        chk("t1_nvalid", 64'(n_valid), 64'd1);
        chk("t1_words", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("t1_word0", 64'(got[0]), 64'h4321);

        // 2: backpressure, then overlapped pop at handoff
        clear_stats();
        ready_v = 1'b0;
        load(1, 8);
        run(6);
        #1;
        chk("t2_hold_valid", 64'(out_valid), 64'd1);
        chk("t2_hold_data", 64'(out_data), 64'h4321);
        chk("t2_hold_ren", 64'(fifo_ren), 64'd0);
        chk("t2_pops_held", 64'(n_pops), 64'd4);
        chk("t2_no_word", 64'(got.size()), 64'd0);
        ready_v = 1'b1;
        run(8);
        chk("t2_pops", 64'(n_pops), 64'd8);
        chk("t2_words", 64'(got.size()), 64'd2);
        if (got.size() > 1) begin
            chk("t2_word0", 64'(got[0]), 64'h4321);
            chk("t2_word1", 64'(got[1]), 64'h8765);
        end

        // 3: streaming, no bubbles
        clear_stats();
        load(0, 12);
        run(16);
        chk("t3_pops", 64'(n_pops), 64'd12);
        chk("t3_span", 64'(last_pop - first_pop + 1), 64'd12);
        chk("t3_nvalid", 64'(n_valid), 64'd3);
        chk("t3_words", 64'(got.size()), 64'd3);
        if (got.size() > 2) begin
            chk("t3_word0", 64'(got[0]), 64'h3210);
            chk("t3_word1", 64'(got[1]), 64'h7654);
            chk("t3_word2", 64'(got[2]), 64'hBA98);
        end

        // 4: sparse input
        clear_stats();
        sparse = 1'b1;
        load(5, 4);
        run(14);
        sparse = 1'b0;
        run(2);
        chk("t4_pops", 64'(n_pops), 64'd4);
        chk("t4_words", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("t4_word0", 64'(got[0]), 64'h8765);

        // 5: asynchronous reset mid-word
        load(9, 2);
        run(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear_stats();
        load(12, 4);
        run(8);
        chk("t5_words", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("t5_word0", 64'(got[0]), 64'hFEDC);

`ifdef FIFO_RD_PACKER_FLUSH_EN
        // 6: flush of a partial word, then flush with nothing collected
        clear_stats();
        load(10, 4);
        run(3);
        flush_v = 1'b1;
        step();
        #1;
        chk("t6_flush_ren", 64'(fifo_ren), 64'd0);
        flush_v = 1'b0;
        step();
        #1;
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_data", 64'(out_data), 64'h0CBA);
        chk("t6_lanes", 64'(out_lanes_w), 64'd3);
        step();
        flush_v = 1'b1;
        step();
        flush_v = 1'b0;
        run(3);
        flush_v = 1'b1;
        run(3);
        flush_v = 1'b0;
        run(2);
        chk("t6_words", 64'(got.size()), 64'd2);
        if (got.size() > 1) begin
            chk("t6_word0", 64'(got[0]), 64'h0CBA);
            chk("t6_word1", 64'(got[1]), 64'h000D);
        end
`endif

        run(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
